// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file, forwarding/writeback bypass, load-use
// scoreboard and the decode->execute operand latch.
module operand_fetch #(
    parameter  int XLEN       = 32,
    parameter  int NREG       = 32,
    parameter  int FWD_STAGES = 2,
    parameter  int CNT_W      = 16,
    localparam int AW         = $clog2(NREG)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [AW-1:0]              rs1,
    input  logic [AW-1:0]              rs2,
    input  logic                       use_rs1,
    input  logic                       use_rs2,
    input  logic [AW-1:0]              rd,
    input  logic                       rd_we,
    input  logic                       is_load,
    output logic                       issue_ready,
    input  logic                       hold,
    input  logic                       flush,
    input  logic [FWD_STAGES-1:0]      fwd_valid,
    input  logic [FWD_STAGES*AW-1:0]   fwd_rd,
    input  logic [FWD_STAGES*XLEN-1:0] fwd_data,
    input  logic                       wb_en,
    input  logic [AW-1:0]              wb_rd,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       ld_done,
    input  logic [AW-1:0]              ld_rd,
    output logic                       op_valid,
    output logic [XLEN-1:0]            op_a,
    output logic [XLEN-1:0]            op_b,
    output logic [AW-1:0]              op_rd,
    output logic                       op_rd_we,
    output logic                       op_is_load,
    output logic [CNT_W-1:0]           stall_cycles
);

    logic [XLEN-1:0]  rf_q [NREG];
    logic [NREG-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             op_valid_q, op_valid_d;
    logic [XLEN-1:0]  op_a_q, op_a_d;
    logic [XLEN-1:0]  op_b_q, op_b_d;
    logic [AW-1:0]    op_rd_q, op_rd_d;
    logic             op_rd_we_q, op_rd_we_d;
    logic             op_is_load_q, op_is_load_d;

    logic [AW-1:0]    src_idx [2];
    logic [XLEN-1:0]  src_val [2];
    logic             src_hit [2];
    logic             haz_rs1, haz_rs2, hazard, fire;

    assign src_idx[0] = rs1;
    assign src_idx[1] = rs2;

    // Lowest-numbered matching forward source wins, then writeback, then the array.
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            src_hit[s] = 1'b0;
            src_val[s] = rf_q[src_idx[s]];
            for (int unsigned i = 0; i < FWD_STAGES; i++) begin
                if (!src_hit[s] && fwd_valid[i] && fwd_rd[i*AW +: AW] == src_idx[s]) begin
                    src_hit[s] = 1'b1;
                    src_val[s] = fwd_data[i*XLEN +: XLEN];
                end
            end
            if (!src_hit[s] && wb_en && wb_rd == src_idx[s]) begin
                src_val[s] = wb_data;
            end
            if (src_idx[s] == '0) begin
                src_val[s] = '0;
            end
        end
    end

    // A load completing this cycle is served by the wb bypass, so it does not stall.
    assign haz_rs1     = use_rs1 && pend_q[rs1] && !(ld_done && ld_rd == rs1);
    assign haz_rs2     = use_rs2 && pend_q[rs2] && !(ld_done && ld_rd == rs2);
    assign hazard      = valid_in && (haz_rs1 || haz_rs2);
    assign issue_ready = !hazard && !hold && !flush;
    assign fire        = valid_in && issue_ready;

    always_comb begin
        pend_d = pend_q;
        if (ld_done) begin
            pend_d[ld_rd] = 1'b0;
        end
        if (fire && is_load && rd_we && rd != '0) begin
            pend_d[rd] = 1'b1;
        end
        if (flush) begin
            pend_d = '0;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        stall_d = stall_q;
        if (valid_in && hazard && !flush && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_comb begin
        op_valid_d   = 1'b0;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_rd_d      = op_rd_q;
        op_rd_we_d   = op_rd_we_q;
        op_is_load_d = op_is_load_q;
        if (flush) begin
            op_valid_d = 1'b0;
        end else if (hold) begin
            op_valid_d = op_valid_q;
        end else if (fire) begin
            op_valid_d   = 1'b1;
            op_a_d       = src_val[0];
            op_b_d       = src_val[1];
            op_rd_d      = rd;
            op_rd_we_d   = rd_we;
            op_is_load_d = is_load;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en && wb_rd != '0) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q       <= '0;
            stall_q      <= '0;
            op_valid_q   <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_rd_q      <= '0;
            op_rd_we_q   <= 1'b0;
            op_is_load_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            stall_q      <= stall_d;
            op_valid_q   <= op_valid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_rd_q      <= op_rd_d;
            op_rd_we_q   <= op_rd_we_d;
            op_is_load_q <= op_is_load_d;
        end
    end

    assign op_valid     = op_valid_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_rd        = op_rd_q;
    assign op_rd_we     = op_rd_we_q;
    assign op_is_load   = op_is_load_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: operand table, hand-written hazard sequences and
// randomized traffic, all checked against a behavioural model.
module tb_operand_fetch;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int FWD  = 2;
    localparam int CNTW = 16;
    localparam int AW   = 5;
    localparam int SATMAX = 65535;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_in, use_rs1, use_rs2, rd_we, is_load, hold, flush;
    logic [AW-1:0]   rs1, rs2, rd;
    logic            issue_ready;
    logic [FWD-1:0]  fwd_valid;
    logic [FWD*AW-1:0]   fwd_rd;
    logic [FWD*XLEN-1:0] fwd_data;
    logic            wb_en, ld_done;
    logic [AW-1:0]   wb_rd, ld_rd;
    logic [XLEN-1:0] wb_data;
    logic            op_valid, op_rd_we, op_is_load;
    logic [XLEN-1:0] op_a, op_b;
    logic [AW-1:0]   op_rd;
    logic [CNTW-1:0] stall_cycles;

    operand_fetch #(.XLEN(XLEN), .NREG(NREG), .FWD_STAGES(FWD), .CNT_W(CNTW)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .rs1(rs1), .rs2(rs2),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .rd(rd), .rd_we(rd_we), .is_load(is_load),
        .issue_ready(issue_ready), .hold(hold), .flush(flush),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ld_done(ld_done), .ld_rd(ld_rd),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
        .op_rd_we(op_rd_we), .op_is_load(op_is_load), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [XLEN-1:0] m_rf [NREG];
    bit              m_pend [NREG];
    logic            m_opv, m_oprdwe, m_opld;
    logic [XLEN-1:0] m_opa, m_opb;
    logic [AW-1:0]   m_oprd;
    int              m_stall;
    logic            obs_ready;

    typedef struct packed {
        logic [4:0]  rs1, rs2;
        logic [1:0]  fv;
        logic [4:0]  frd0, frd1;
        logic [31:0] fd0, fd1;
        logic        wbe;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic [31:0] ea, eb;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_rf[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_opv = 1'b0; m_opa = '0; m_opb = '0; m_oprd = '0;
        m_oprdwe = 1'b0; m_opld = 1'b0; m_stall = 0;
    endtask

    function automatic logic [XLEN-1:0] mres(input logic [AW-1:0] rs);
        if (rs == 0) return '0;
        for (int i = 0; i < FWD; i++)
            if (fwd_valid[i] && fwd_rd[i*AW +: AW] == rs) return fwd_data[i*XLEN +: XLEN];
        if (wb_en && wb_rd == rs) return wb_data;
        return m_rf[rs];
    endfunction

    task automatic idle();
        valid_in = 0; use_rs1 = 0; use_rs2 = 0; rd_we = 0; is_load = 0; hold = 0; flush = 0;
        rs1 = '0; rs2 = '0; rd = '0; fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
        wb_en = 0; wb_rd = '0; wb_data = '0; ld_done = 0; ld_rd = '0;
    endtask

    // Inputs are driven at posedge+1; combinational check mid-cycle, registered check at posedge+1.
    task automatic cyc();
        logic hz, rdy, fr;
        logic [XLEN-1:0] ra, rb;
        #4;
        hz = valid_in && ((use_rs1 && m_pend[rs1] && !(ld_done && ld_rd == rs1)) ||
                          (use_rs2 && m_pend[rs2] && !(ld_done && ld_rd == rs2)));
        rdy = !hz && !hold && !flush;
        obs_ready = issue_ready;
        chk("issue_ready", 64'(issue_ready), 64'(rdy));
        fr = valid_in && rdy;
        ra = mres(rs1);
        rb = mres(rs2);
        if (valid_in && hz && !flush && m_stall < SATMAX) m_stall++;
        if (flush) m_opv = 1'b0;
        else if (hold) m_opv = m_opv;
        else if (fr) begin
            m_opv = 1'b1; m_opa = ra; m_opb = rb; m_oprd = rd; m_oprdwe = rd_we; m_opld = is_load;
        end else m_opv = 1'b0;
        if (ld_done) m_pend[ld_rd] = 1'b0;
        if (fr && is_load && rd_we && rd != 0) m_pend[rd] = 1'b1;
        if (flush) for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
        @(posedge clk);
        #1;
        chk("op_valid", 64'(op_valid), 64'(m_opv));
        if (m_opv) begin
            chk("op_a", 64'(op_a), 64'(m_opa));
            chk("op_b", 64'(op_b), 64'(m_opb));
            chk("op_rd", 64'(op_rd), 64'(m_oprd));
            chk("op_rd_we", 64'(op_rd_we), 64'(m_oprdwe));
            chk("op_is_load", 64'(op_is_load), 64'(m_opld));
        end
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_op_valid"}, 64'(op_valid), 64'd0);
        chk({nm, "_op_a"}, 64'(op_a), 64'd0);
        chk({nm, "_op_b"}, 64'(op_b), 64'd0);
        chk({nm, "_op_rd"}, 64'(op_rd), 64'd0);
        chk({nm, "_op_rd_we"}, 64'(op_rd_we), 64'd0);
        chk({nm, "_op_is_load"}, 64'(op_is_load), 64'd0);
        chk({nm, "_stall"}, 64'(stall_cycles), 64'd0);
    endtask

    initial begin
        tbl[0] = '{5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,    32'h1234, 32'h0};
        tbl[1] = '{5'd5, 5'd0, 2'b11, 5'd5, 5'd5, 32'hAAAA, 32'hBBBB, 1'b1, 5'd5, 32'hCCCC, 32'hAAAA, 32'h0};
        tbl[2] = '{5'd5, 5'd0, 2'b00, 5'd5, 5'd5, 32'hAAAA, 32'hBBBB, 1'b1, 5'd5, 32'hCCCC, 32'hCCCC, 32'h0};
        tbl[3] = '{5'd5, 5'd5, 2'b10, 5'd5, 5'd5, 32'hAAAA, 32'hBBBB, 1'b0, 5'd0, 32'h0,    32'hBBBB, 32'hBBBB};
        tbl[4] = '{5'd0, 5'd5, 2'b01, 5'd0, 5'd0, 32'hDEAD, 32'h0,    1'b0, 5'd0, 32'h0,    32'h0,    32'hCCCC};
        tbl[5] = '{5'd0, 5'd9, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    1'b1, 5'd0, 32'h77,   32'h0,    32'h0};
        tbl[6] = '{5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    1'b1, 5'd9, 32'h99,   32'h99,   32'h0};
        tbl[7] = '{5'd9, 5'd5, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,    32'h99,   32'hCCCC};
        tbl[8] = '{5'd3, 5'd9, 2'b11, 5'd3, 5'd9, 32'h33,   32'h1111, 1'b0, 5'd0, 32'h0,    32'h33,   32'h1111};

        idle();
        rst = 1'b0;
        model_reset();
        #12;
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        idle(); wb_en = 1; wb_rd = 5'd5; wb_data = 32'h1234; cyc();

        for (int v = 0; v < 9; v++) begin
            idle();
            valid_in = 1; use_rs1 = 1; use_rs2 = 1; rd = 5'd1; rd_we = 1;
            rs1 = tbl[v].rs1; rs2 = tbl[v].rs2;
            fwd_valid = tbl[v].fv;
            fwd_rd = {tbl[v].frd1, tbl[v].frd0};
            fwd_data = {tbl[v].fd1, tbl[v].fd0};
            wb_en = tbl[v].wbe; wb_rd = tbl[v].wbrd; wb_data = tbl[v].wbd;
            cyc();
            chk("tbl_op_valid", 64'(op_valid), 64'd1);
            chk("tbl_op_a", 64'(op_a), 64'(tbl[v].ea));
            chk("tbl_op_b", 64'(op_b), 64'(tbl[v].eb));
        end

        // load-use stall
        idle(); valid_in = 1; is_load = 1; rd = 5'd7; rd_we = 1; cyc();
        chk("lu_load_ready", 64'(obs_ready), 64'd1);
        idle(); valid_in = 1; use_rs2 = 1; rs2 = 5'd7; rd = 5'd8; rd_we = 1;
        repeat (3) begin
            cyc();
            chk("lu_stall_ready", 64'(obs_ready), 64'd0);
        end
        chk("lu_stall_cnt", 64'(stall_cycles), 64'd3);
        ld_done = 1; ld_rd = 5'd7; wb_en = 1; wb_rd = 5'd7; wb_data = 32'h55; cyc();
        chk("lu_ready", 64'(obs_ready), 64'd1);
        chk("lu_op_valid", 64'(op_valid), 64'd1);
        chk("lu_op_b", 64'(op_b), 64'h55);

        // flush clears the scoreboard
        idle(); valid_in = 1; is_load = 1; rd = 5'd7; rd_we = 1; cyc();
        idle(); valid_in = 1; use_rs1 = 1; rs1 = 5'd7; rd = 5'd9; rd_we = 1; flush = 1; cyc();
        chk("fl_ready", 64'(obs_ready), 64'd0);
        chk("fl_op_valid", 64'(op_valid), 64'd0);
        flush = 0; cyc();
        chk("fl_refire", 64'(obs_ready), 64'd1);
        chk("fl_op_valid2", 64'(op_valid), 64'd1);
        chk("fl_op_a", 64'(op_a), 64'h55);
        chk("fl_stall", 64'(stall_cycles), 64'd3);

        // hold freezes the latch
        idle(); valid_in = 1; use_rs1 = 1; rs1 = 5'd5; rd = 5'd3; rd_we = 1; cyc();
        hold = 1; rs1 = 5'd9; rd = 5'd4;
        repeat (2) begin
            cyc();
            chk("hold_ready", 64'(obs_ready), 64'd0);
            chk("hold_op_valid", 64'(op_valid), 64'd1);
            chk("hold_op_a", 64'(op_a), 64'hCCCC);
            chk("hold_op_rd", 64'(op_rd), 64'd3);
        end

        // same-cycle clear and set of x7: set wins
        idle(); valid_in = 1; is_load = 1; rd = 5'd7; rd_we = 1; cyc();
        ld_done = 1; ld_rd = 5'd7; wb_en = 1; wb_rd = 5'd7; wb_data = 32'h66; cyc();
        chk("sw_load2_ready", 64'(obs_ready), 64'd1);
        idle(); valid_in = 1; use_rs1 = 1; rs1 = 5'd7; rd = 5'd2; rd_we = 1; cyc();
        chk("sw_stall", 64'(obs_ready), 64'd0);
        ld_done = 1; ld_rd = 5'd7; wb_en = 1; wb_rd = 5'd7; wb_data = 32'h77; cyc();
        chk("sw_ready", 64'(obs_ready), 64'd1);
        chk("sw_op_a", 64'(op_a), 64'h77);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            use_rs1 = 1'($urandom_range(0, 1));
            use_rs2 = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 7));
            rd_we = ($urandom_range(0, 3) != 0);
            is_load = ($urandom_range(0, 2) == 0);
            hold = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            fwd_valid = 2'($urandom_range(0, 3));
            fwd_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_data = {$urandom(), $urandom()};
            ld_done = ($urandom_range(0, 2) == 0);
            ld_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom();
            if (ld_done) begin
                wb_en = 1; wb_rd = ld_rd;
            end else begin
                wb_en = 1'($urandom_range(0, 1));
                wb_rd = 5'($urandom_range(0, 7));
            end
            cyc();
        end

        // stall counter saturation, then reset mid-stall
        idle(); flush = 1; cyc();
        idle(); valid_in = 1; is_load = 1; rd = 5'd7; rd_we = 1; cyc();
        idle(); valid_in = 1; use_rs2 = 1; rs2 = 5'd7;
        repeat (65539) cyc();
        chk("sat_cnt", 64'(stall_cycles), 64'hFFFF);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_zero("midrst");
        chk("midrst_ready", 64'(issue_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc();
        chk("post_rst_fire", 64'(op_valid), 64'd1);
        chk("post_rst_stall", 64'(stall_cycles), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Parametrised operand-fetch stage for the RV32I pipeline. It holds the architectural register file and resolves source operands through an N-deep forwarding network plus a writeback bypass. A per-register load scoreboard stalls issue on load-use hazards. Resolved operands are registered into a decode→execute operand latch; the block sits between instruction decode and the execute stage.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREG, 32, number of architectural registers; AW = $clog2(NREG)
- FWD_STAGES, 2, forwarding sources; index 0 is youngest and has highest priority
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  decoded instruction present
- rs1, rs2  in  AW  source register indices
- use_rs1, use_rs2  in  1  the instruction reads that source
- rd  in  AW  destination index
- rd_we  in  1  the instruction writes rd
- is_load  in  1  the instruction is a load
- issue_ready  out  1  the instruction is accepted this cycle
- hold  in  1  execute stall; freezes the operand latch
- flush  in  1  squash the latch and clear the scoreboard
- fwd_valid  in  FWD_STAGES  forward source valid
- fwd_rd  in  FWD_STAGES*AW  forward destinations, packed
- fwd_data  in  FWD_STAGES*XLEN  forward results, packed
- wb_en, wb_rd, wb_data  in  1/AW/XLEN  register-file write port
- ld_done, ld_rd  in  1/AW  load result arrives this cycle; it must coincide with the wb write of ld_rd
- op_valid  out  1  operand latch valid
- op_a, op_b  out  XLEN  resolved rs1/rs2 values
- op_rd  out  AW  latched rd
- op_rd_we, op_is_load  out  1  latched controls
- stall_cycles  out  CNT_W  saturating count of hazard stalls

## Operation
- Register file: NREG×XLEN. All entries are cleared at reset. Writes happen on the clk edge when wb_en=1 and wb_rd≠0. x0 always reads 0.
- Operand resolution (combinational, per source, x0 → 0):
  - first, the lowest i with fwd_valid[i] and fwd_rd[i]==rs;
  - else wb_data if wb_en and wb_rd==rs;
  - else the array value.
- Scoreboard pend[NREG]:
  - Set on fire when is_load=1, rd_we=1 and rd≠0.
  - Cleared on ld_done for ld_rd.
  - Set and clear of the same register in the same cycle: set wins.
  - pend[0] is never set.
- Hazard = valid_in and, for either source (use_rsX=1), pend[rsX]=1 and not (ld_done and ld_rd==rsX). A load completing this cycle is bypassed through the wb path, not stalled.
- issue_ready = !hazard & !hold & !flush. fire = valid_in & issue_ready.
- Operand latch, by priority:
  1. flush: op_valid←0.
  2. Else hold: all op_* keep their values.
  3. Else fire: op_valid←1 and op_a/op_b/op_rd/op_rd_we/op_is_load ← resolved/decoded values.
  4. Otherwise: op_valid←0 and data is don't-care.
- flush also clears every pend bit, overriding a same-cycle set. Writes to the register file are unaffected by flush.
- stall_cycles increments each cycle that valid_in & hazard & !flush. It saturates at all-ones and is cleared only by reset.
- Unused-source operands still resolve; their values are don't-care to execute.

## Timing
- Reset (rst=0, async) sets: op_valid=0, op_a=op_b=0, op_rd=0, op_rd_we=0, op_is_load=0, stall_cycles=0, pend=0, register file=0.
- Latency: fire in cycle N → op_* valid in cycle N+1.
- A regfile write in cycle N is visible to a same-cycle read through the bypass, and from the array in N+1.
- Load-use timing: a load fires in N; a dependent instruction is presented in N+1 and stalls until the cycle in which ld_done for that rd is asserted. It fires in that cycle.
- Reset asserted mid-stall drops all state. After release, issue_ready depends only on hold/flush.
- A forward source hitting x0 is ignored.

## Test plan
- Reset, then write x5=0x1234 via wb. Next cycle, issue rs1=5, rs2=0 → op_a=0x1234, op_b=0 one cycle after fire.
- fwd_valid=2'b11, fwd_rd={5,5}, fwd_data={0xBBBB,0xAAAA}, wb_rd=5 with 0xCCCC → op_a=0xAAAA (stage 0 wins). Drop fwd_valid → op_a=0xCCCC.
- Load to x7 fires. Consumer with use_rs2=1, rs2=7 follows → issue_ready=0 for 3 cycles and stall_cycles=3. Then ld_done with ld_rd=7 and wb_data=0x55 → fire that cycle, op_b=0x55.
- Load to x7 fires, then flush with the consumer pending → pend cleared, op_valid=0, and the consumer fires next cycle with no stall.
- hold=1 for 2 cycles with op_valid=1 → op_* unchanged and issue_ready=0. A simultaneous ld_done and new load set on the same rd → pend stays 1.
- Force the stall count to 2^CNT_W+3 hazard cycles → stall_cycles saturates at 0xFFFF. Assert rst low mid-stall → all outputs return to 0 immediately.
